// File: rtl/fsm_cmp_checker_if.sv
// Bus bundle between the good/bad FSM pair and the comparison checker:
// control strobes and sample inputs, plus the held measurement results.
interface fsm_cmp_checker_if #(
  parameter int SampleWidth = 16,
  parameter int ErrWidth    = 8
);
  logic                   start_i;
  logic                   stop_i;
  logic                   valid_i;
  logic [15:0]            data_i;
  logic [1:0]             flag_i;

  logic                   busy_o;
  logic                   done_o;
  logic                   pass_o;
  logic                   mismatch_o;
  logic [ErrWidth-1:0]    err_cnt_o;
  logic [SampleWidth-1:0] sample_cnt_o;
  logic [SampleWidth-1:0] first_idx_o;
  logic [15:0]            first_data_o;
  logic [1:0]             first_flag_o;
  logic                   err_o;

  modport master (
    output start_i, stop_i, valid_i, data_i, flag_i,
    input  busy_o, done_o, pass_o, mismatch_o, err_cnt_o, sample_cnt_o,
           first_idx_o, first_data_o, first_flag_o, err_o
  );

  modport slave (
    input  start_i, stop_i, valid_i, data_i, flag_i,
    output busy_o, done_o, pass_o, mismatch_o, err_cnt_o, sample_cnt_o,
           first_idx_o, first_data_o, first_flag_o, err_o
  );
endinterface

// File: rtl/fsm_cmp_checker.sv
// Cycle-by-cycle comparator for the dual-FSM output bus: counts mismatches over
// a start/stop window and captures the first failing sample for later readout.
module fsm_cmp_checker #(
  parameter int SampleWidth = 16,
  parameter int ErrWidth    = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  fsm_cmp_checker_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // The counter closes the window one short of all-ones so it never wraps.
  localparam logic [SampleWidth-1:0] SampleLast = {{(SampleWidth-1){1'b1}}, 1'b0};

  state_t                 r_state;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pass;
  logic                   r_mismatch;
  logic                   r_err;
  logic [ErrWidth-1:0]    r_err_cnt;
  logic [SampleWidth-1:0] r_sample_cnt;
  logic [SampleWidth-1:0] r_first_idx;
  logic [15:0]            r_first_data;
  logic [1:0]             r_first_flag;

  logic w_sample;
  logic w_mis;
  logic w_limit;
  logic w_err_sat;

  always_comb begin
    w_sample  = bus.valid_i;
    w_mis     = w_sample && ((bus.data_i[15:8] != bus.data_i[7:0]) ||
                             (bus.flag_i[1] != bus.flag_i[0]));
    w_limit   = w_sample && (r_sample_cnt == SampleLast);
    w_err_sat = &r_err_cnt;
  end

  // NOTE: state and every output register use non-blocking assignments in one
  // clocked block; all of them are small flops, so each gets an explicit reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_mismatch   <= 1'b0;
      r_err        <= 1'b0;
      r_err_cnt    <= '0;
      r_sample_cnt <= '0;
      r_first_idx  <= '0;
      r_first_data <= '0;
      r_first_flag <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_mismatch <= 1'b0;
          if (bus.start_i) begin
            r_state      <= S_RUN;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= 1'b0;
            r_err_cnt    <= '0;
            r_sample_cnt <= '0;
            r_first_idx  <= '0;
            r_first_data <= '0;
            r_first_flag <= '0;
          end
        end
        S_RUN: begin
          r_mismatch <= w_mis;
          if (w_sample) r_sample_cnt <= r_sample_cnt + 1'b1;
          if (w_mis) begin
            if (!w_err_sat) r_err_cnt <= r_err_cnt + 1'b1;
            r_err <= 1'b1;
            if (!r_err) begin
              r_first_idx  <= r_sample_cnt;
              r_first_data <= bus.data_i;
              r_first_flag <= bus.flag_i;
            end
          end
          if (bus.stop_i || w_limit) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            // Includes the sample compared on this same edge.
            r_pass  <= !(r_err || w_mis);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o       = r_busy;
  assign bus.done_o       = r_done;
  assign bus.pass_o       = r_pass;
  assign bus.mismatch_o   = r_mismatch;
  assign bus.err_cnt_o    = r_err_cnt;
  assign bus.sample_cnt_o = r_sample_cnt;
  assign bus.first_idx_o  = r_first_idx;
  assign bus.first_data_o = r_first_data;
  assign bus.first_flag_o = r_first_flag;
  assign bus.err_o        = r_err;
endmodule

// File: tb/tb_fsm_cmp_checker.sv
// Directed bench for fsm_cmp_checker: a default-width instance for the main
// scenarios and a SampleWidth=4 instance for the sample-limit boundary.
module tb_fsm_cmp_checker;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk_i = ~clk_i;

  fsm_cmp_checker_if #(.SampleWidth(16), .ErrWidth(8)) abus ();
  fsm_cmp_checker_if #(.SampleWidth(4),  .ErrWidth(8)) bbus ();

  fsm_cmp_checker #(.SampleWidth(16), .ErrWidth(8)) u_dut_a (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (abus)
  );

  fsm_cmp_checker #(.SampleWidth(4), .ErrWidth(8)) u_dut_b (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bbus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one cycle on instance A, then return strobes to idle.
  task automatic go(input logic st, input logic sp, input logic v,
                    input logic [15:0] d, input logic [1:0] f);
    abus.start_i = st;
    abus.stop_i  = sp;
    abus.valid_i = v;
    abus.data_i  = d;
    abus.flag_i  = f;
    tick();
    abus.start_i = 1'b0;
    abus.stop_i  = 1'b0;
    abus.valid_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  {31'd0, abus.busy_o},     32'd0);
    check({tag, "_done"},  {31'd0, abus.done_o},     32'd0);
    check({tag, "_pass"},  {31'd0, abus.pass_o},     32'd0);
    check({tag, "_mis"},   {31'd0, abus.mismatch_o}, 32'd0);
    check({tag, "_err"},   {31'd0, abus.err_o},      32'd0);
    check({tag, "_ecnt"},  {24'd0, abus.err_cnt_o},  32'd0);
    check({tag, "_scnt"},  {16'd0, abus.sample_cnt_o}, 32'd0);
    check({tag, "_fidx"},  {16'd0, abus.first_idx_o},  32'd0);
    check({tag, "_fdata"}, {16'd0, abus.first_data_o}, 32'd0);
    check({tag, "_fflag"}, {30'd0, abus.first_flag_o}, 32'd0);
  endtask

  initial begin
    abus.start_i = 1'b0; abus.stop_i = 1'b0; abus.valid_i = 1'b0;
    abus.data_i  = '0;   abus.flag_i = '0;
    bbus.start_i = 1'b0; bbus.stop_i = 1'b0; bbus.valid_i = 1'b0;
    bbus.data_i  = '0;   bbus.flag_i = '0;

    // Reset state
    #12;
    check_all_zero("reset");
    tick();
    rst_ni = 1'b1;
    go(1'b0, 1'b1, 1'b1, 16'h0102, 2'b10);
    check("idle_ignores_stop_valid", {16'd0, abus.sample_cnt_o}, 32'd0);
    check("idle_busy", {31'd0, abus.busy_o}, 32'd0);

    // Clean window of 4 matching samples
    go(1'b1, 1'b0, 1'b0, 16'h0000, 2'b00);
    check("t1_busy", {31'd0, abus.busy_o}, 32'd1);
    for (int i = 0; i < 4; i++) go(1'b0, 1'b0, 1'b1, 16'hA5A5, 2'b11);
    check("t1_busy_before_stop", {31'd0, abus.busy_o}, 32'd1);
    go(1'b0, 1'b1, 1'b0, 16'h0000, 2'b00);
    check("t1_done", {31'd0, abus.done_o}, 32'd1);
    check("t1_busy_off", {31'd0, abus.busy_o}, 32'd0);
    check("t1_pass", {31'd0, abus.pass_o}, 32'd1);
    check("t1_scnt", {16'd0, abus.sample_cnt_o}, 32'd4);
    check("t1_ecnt", {24'd0, abus.err_cnt_o}, 32'd0);
    check("t1_err", {31'd0, abus.err_o}, 32'd0);
    check("t1_fdata", {16'd0, abus.first_data_o}, 32'd0);

    // Single byte mismatch at sample 3; start from DONE
    go(1'b1, 1'b0, 1'b0, 16'h0000, 2'b00);
    check("t2_restart_busy", {31'd0, abus.busy_o}, 32'd1);
    check("t2_restart_done", {31'd0, abus.done_o}, 32'd0);
    check("t2_restart_scnt", {16'd0, abus.sample_cnt_o}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      go(1'b0, 1'b0, 1'b1, (i == 3) ? 16'h3C3D : 16'h5A5A, 2'b00);
      check($sformatf("t2_mis_pulse_%0d", i), {31'd0, abus.mismatch_o}, (i == 3) ? 32'd1 : 32'd0);
    end
    go(1'b0, 1'b1, 1'b0, 16'h0000, 2'b00);
    check("t2_mis_after_stop", {31'd0, abus.mismatch_o}, 32'd0);
    check("t2_ecnt", {24'd0, abus.err_cnt_o}, 32'd1);
    check("t2_scnt", {16'd0, abus.sample_cnt_o}, 32'd6);
    check("t2_fidx", {16'd0, abus.first_idx_o}, 32'd3);
    check("t2_fdata", {16'd0, abus.first_data_o}, 32'h3C3D);
    check("t2_fflag", {30'd0, abus.first_flag_o}, 32'd0);
    check("t2_pass", {31'd0, abus.pass_o}, 32'd0);
    check("t2_err", {31'd0, abus.err_o}, 32'd1);

    // Flag-only mismatch first, byte mismatch later; start ignored in RUN
    go(1'b1, 1'b0, 1'b0, 16'h0000, 2'b00);
    go(1'b0, 1'b0, 1'b1, 16'h7777, 2'b10);
    go(1'b1, 1'b0, 1'b1, 16'h1111, 2'b11);
    check("t3_start_ignored_run", {16'd0, abus.sample_cnt_o}, 32'd2);
    go(1'b0, 1'b0, 1'b1, 16'h1211, 2'b00);
    go(1'b0, 1'b1, 1'b0, 16'h0000, 2'b00);
    check("t3_ecnt", {24'd0, abus.err_cnt_o}, 32'd2);
    check("t3_fidx", {16'd0, abus.first_idx_o}, 32'd0);
    check("t3_fflag", {30'd0, abus.first_flag_o}, 32'd2);
    check("t3_fdata", {16'd0, abus.first_data_o}, 32'h7777);

    // 300 mismatches saturate the 8-bit error counter
    go(1'b1, 1'b0, 1'b0, 16'h0000, 2'b00);
    for (int i = 0; i < 300; i++) begin
      go(1'b0, 1'b0, 1'b1, 16'h0001, 2'b00);
      if (i == 254) check("t4_ecnt_at_255", {24'd0, abus.err_cnt_o}, 32'd255);
    end
    go(1'b0, 1'b1, 1'b0, 16'h0000, 2'b00);
    check("t4_ecnt_sat", {24'd0, abus.err_cnt_o}, 32'd255);
    check("t4_scnt", {16'd0, abus.sample_cnt_o}, 32'd300);
    check("t4_fidx", {16'd0, abus.first_idx_o}, 32'd0);
    check("t4_fdata", {16'd0, abus.first_data_o}, 32'h0001);

    // Stop together with a mismatching sample; DONE ignores further samples
    go(1'b1, 1'b0, 1'b0, 16'h0000, 2'b00);
    go(1'b0, 1'b1, 1'b1, 16'h0102, 2'b00);
    check("t5_done", {31'd0, abus.done_o}, 32'd1);
    check("t5_ecnt", {24'd0, abus.err_cnt_o}, 32'd1);
    check("t5_scnt", {16'd0, abus.sample_cnt_o}, 32'd1);
    check("t5_mis", {31'd0, abus.mismatch_o}, 32'd1);
    check("t5_pass", {31'd0, abus.pass_o}, 32'd0);
    for (int i = 0; i < 3; i++) go(1'b0, 1'b0, 1'b1, 16'h0F00, 2'b01);
    check("t5_done_hold_ecnt", {24'd0, abus.err_cnt_o}, 32'd1);
    check("t5_done_hold_scnt", {16'd0, abus.sample_cnt_o}, 32'd1);
    check("t5_done_hold_mis", {31'd0, abus.mismatch_o}, 32'd0);
    check("t5_done_hold_fdata", {16'd0, abus.first_data_o}, 32'h0102);

    // Start and stop together in DONE: start wins
    go(1'b1, 1'b1, 1'b0, 16'h0000, 2'b00);
    check("t6_start_wins_busy", {31'd0, abus.busy_o}, 32'd1);
    check("t6_start_wins_done", {31'd0, abus.done_o}, 32'd0);

    // Asynchronous reset mid-window after two errors
    go(1'b0, 1'b0, 1'b1, 16'h00FF, 2'b00);
    go(1'b0, 1'b0, 1'b1, 16'h0000, 2'b01);
    check("t6_ecnt_pre_reset", {24'd0, abus.err_cnt_o}, 32'd2);
    #2;
    rst_ni = 1'b0;
    #1;
    check_all_zero("t6_async_reset");
    tick();
    rst_ni = 1'b1;
    go(1'b1, 1'b0, 1'b0, 16'h0000, 2'b00);
    go(1'b0, 1'b1, 1'b0, 16'h0000, 2'b00);
    check("t6_empty_done", {31'd0, abus.done_o}, 32'd1);
    check("t6_empty_pass", {31'd0, abus.pass_o}, 32'd1);
    check("t6_empty_scnt", {16'd0, abus.sample_cnt_o}, 32'd0);

    // Sample limit on the SampleWidth=4 instance: 15 samples end the window
    bbus.start_i = 1'b1;
    tick();
    bbus.start_i = 1'b0;
    bbus.valid_i = 1'b1;
    bbus.data_i  = 16'h4242;
    bbus.flag_i  = 2'b00;
    for (int i = 0; i < 14; i++) tick();
    check("t7_busy_at_14", {31'd0, bbus.busy_o}, 32'd1);
    check("t7_scnt_14", {28'd0, bbus.sample_cnt_o}, 32'd14);
    tick();
    check("t7_done_at_15", {31'd0, bbus.done_o}, 32'd1);
    check("t7_busy_off", {31'd0, bbus.busy_o}, 32'd0);
    check("t7_scnt_15", {28'd0, bbus.sample_cnt_o}, 32'd15);
    check("t7_pass", {31'd0, bbus.pass_o}, 32'd1);
    tick();
    tick();
    bbus.valid_i = 1'b0;
    check("t7_scnt_held", {28'd0, bbus.sample_cnt_o}, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fsm_cmp_checker.md
# fsm_cmp_checker

Downstream comparison stage for the dual-FSM block: it consumes the 16-bit output bus and 2-bit flag bus produced by the paired good/bad FSM instances and checks them cycle by cycle. Upper byte and flag bit 1 carry the reference FSM; lower byte and flag bit 0 carry the FSM under test. The block counts mismatching samples over a measurement window and captures the first failing sample. Results are held for readout by the lab test harness.

## Interface

- `SampleWidth`, default 16: width of the sample counter and of the first-error index.
- `ErrWidth`, default 8: width of the mismatch counter.
- `clk_i` in, 1: clock; all state updates on the rising edge.
- `rst_ni` in, 1: asynchronous, active-low reset.
- `start_i` in, 1: opens a measurement window (level sampled each cycle).
- `stop_i` in, 1: closes the window.
- `valid_i` in, 1: current `data_i`/`flag_i` is a sample to compare.
- `data_i` in, 16: [15:8] reference byte, [7:0] compared byte.
- `flag_i` in, 2: [1] reference flag, [0] compared flag.
- `busy_o` out, 1: window open (state RUN).
- `done_o` out, 1: results valid (state DONE).
- `pass_o` out, 1: DONE and zero mismatches.
- `mismatch_o` out, 1: one-cycle pulse per mismatching sample.
- `err_cnt_o` out, ErrWidth: saturating mismatch count.
- `sample_cnt_o` out, SampleWidth: number of samples compared in the window.
- `first_idx_o` out, SampleWidth: sample index (0-based) of the first mismatch.
- `first_data_o` out, 16: `data_i` of the first mismatch.
- `first_flag_o` out, 2: `flag_i` of the first mismatch.
- `err_o` out, 1: at least one mismatch seen in the current or last window.

## Operation

- Three states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: `stop_i` and `valid_i` are ignored. `start_i` moves to RUN and clears all counters, capture registers, `err_o` and `mismatch_o`.
- RUN: each cycle with `valid_i`=1 is one sample.
  - The sample mismatches if `data_i[15:8]`≠`data_i[7:0]` or `flag_i[1]`≠`flag_i[0]`.
  - `sample_cnt_o` increments by 1 per sample.
  - On a mismatch, `err_cnt_o` increments and saturates at 2^ErrWidth−1; `mismatch_o` pulses; `err_o` sets.
  - On the first mismatch only, `first_idx_o` loads the pre-increment `sample_cnt_o`, and `first_data_o`/`first_flag_o` load the sample.
  - `start_i` is ignored in RUN.
- RUN→DONE transitions:
  - On `stop_i`=1. A valid sample in the same cycle is still compared and counted.
  - When a sample is counted while `sample_cnt_o` = 2^SampleWidth−2, so the counter reaches its maximum and never wraps.
- DONE: all results hold and `done_o`=1. `valid_i` and `stop_i` are ignored. `start_i` re-enters RUN with clears, identical to IDLE→RUN.
- `pass_o` = DONE && `err_cnt_o`==0.
- Capture registers stay 0 if no mismatch occurred.

## Timing

- Reset values: every output is 0; state is IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Start latency: `start_i` high at edge N gives `busy_o`=1 and cleared counters after edge N. The first sample is accepted at edge N+1.
- Compare latency: a sample at edge N updates `err_cnt_o`, `sample_cnt_o`, `mismatch_o` and the capture registers after edge N.
- Stop latency: `stop_i` at edge N gives `done_o`=1 and `busy_o`=0 after edge N. The counters already include the edge-N sample.
- Simultaneous events:
  - `start_i` with `stop_i` in IDLE or DONE: start wins and the state goes to RUN.
  - `stop_i` with saturation: the state goes to DONE, once.
- Asynchronous reset mid-window: immediate return to IDLE with all outputs 0. No partial results are retained.

## Test plan

- Reset, then start, then 4 samples with `data_i`=16'hA5A5, `flag_i`=2'b11, then stop: `done_o`=1, `pass_o`=1, `sample_cnt_o`=4, `err_cnt_o`=0, `err_o`=0.
- Start, then samples 0..5 where only sample 3 has `data_i`=16'h3C3D, then stop: `err_cnt_o`=1, `first_idx_o`=3, `first_data_o`=16'h3C3D, `first_flag_o` equals the driven flags, `mismatch_o` high exactly one cycle, `pass_o`=0.
- Flag-only mismatch (`data_i`=16'h7777, `flag_i`=2'b10) at sample 0, then a byte mismatch at sample 2, then stop: `err_cnt_o`=2, `first_idx_o`=0, `first_flag_o`=2'b10.
- 300 consecutive mismatching samples with ErrWidth=8: `err_cnt_o`=255 (saturated), `sample_cnt_o`=300, `first_idx_o`=0.
- `stop_i` asserted together with a mismatching `valid_i` sample: `done_o` next cycle and the sample is counted (`err_cnt_o`=1). `valid_i` pulses applied in DONE leave all counts unchanged.
- Assert `rst_ni`=0 mid-window after 2 errors: all outputs 0 immediately. Then start/stop with no samples: `done_o`=1, `pass_o`=1, `sample_cnt_o`=0. Sample-limit check with SampleWidth=4: 15 samples cause automatic DONE with `sample_cnt_o`=15.
